// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Request/response bundle for the multi-cycle ALU execution unit.
//
// Signals:
//   in_valid  - requester has an operation to issue
//   in_ready  - unit can accept an operation this cycle
//   alu_op    - 4-bit operation code
//   a         - operand A (low 5 bits are the shift amount for shifts)
//   b         - operand B (shifted value for shifts, source for LUI)
//   out_valid - result is present
//   out_ready - consumer takes the result this cycle
//   result    - 32-bit operation result
//   illegal   - result came from an undefined opcode
//
// Modports:
//   master - the requester/consumer side
//   slave  - the execution unit side
// ---------------------------------------------------------------------------
interface alu_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle ALU. Arithmetic and logic ops finish one cycle after they are
// accepted; shifts move the working value one bit per cycle so a shift by n
// finishes n+1 cycles after acceptance. Results are held until consumed.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - alu_exec_unit_if.slave request/response bundle
// ---------------------------------------------------------------------------
module alu_exec_unit (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);

    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  op_r;
    logic [31:0] result_r;
    logic        illegal_r;
    logic [4:0]  cnt_r;
    logic        fill_r;

    logic        is_shift_op;
    logic [4:0]  shamt;
    logic [31:0] alu_value;
    logic        alu_illegal;
    logic [31:0] shift_value;

    assign shamt       = bus.a[4:0];
    assign is_shift_op = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRA) ||
                         (bus.alu_op == OP_SRL);

    // Single-cycle result computed straight from the request inputs. Shifts
    // just pass B through here: it becomes the final result for a zero shift
    // amount, or the starting value of the working register otherwise.
    always_comb begin
        alu_value   = 32'd0;
        alu_illegal = 1'b0;
        case (bus.alu_op)
            OP_ADDU: alu_value = bus.a + bus.b;
            OP_SUBU: alu_value = bus.a - bus.b;
            OP_SLT:  alu_value = {31'd0, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: alu_value = {31'd0, bus.a < bus.b};
            OP_AND:  alu_value = bus.a & bus.b;
            OP_OR:   alu_value = bus.a | bus.b;
            OP_XOR:  alu_value = bus.a ^ bus.b;
            OP_LUI:  alu_value = {bus.b[15:0], 16'h0000};
            OP_SLL:  alu_value = bus.b;
            OP_SRA:  alu_value = bus.b;
            OP_SRL:  alu_value = bus.b;
            OP_NOR:  alu_value = ~(bus.a | bus.b);
            default: begin
                alu_value   = 32'd0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // One-bit step of the working register. SRA fills from the sign bit of
    // the original B, captured at acceptance, rather than the live MSB.
    always_comb begin
        shift_value = result_r;
        case (op_r)
            OP_SLL:  shift_value = {result_r[30:0], 1'b0};
            OP_SRL:  shift_value = {1'b0, result_r[31:1]};
            OP_SRA:  shift_value = {fill_r, result_r[31:1]};
            default: shift_value = result_r;
        endcase
    end

    // Next-state logic. The counter is at 1 on the last shift cycle, since
    // it reaches 0 on the same edge that moves the FSM into DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift_op && (shamt != 5'd0)) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt_r <= 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset overrides any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. The captured request lives in op_r, fill_r, cnt_r
    // and result_r, so the request inputs may change freely after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 4'd0;
            result_r  <= 32'd0;
            illegal_r <= 1'b0;
            cnt_r     <= 5'd0;
            fill_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r      <= bus.alu_op;
                        result_r  <= alu_value;
                        illegal_r <= alu_illegal;
                        fill_r    <= bus.b[31];
                        cnt_r     <= is_shift_op ? shamt : 5'd0;
                    end
                end
                SHIFT: begin
                    result_r <= shift_value;
                    cnt_r    <= cnt_r - 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_r;
    assign bus.illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed vector table plus hand-written sequences for output stalls,
// reset in the middle of a shift and reset colliding with a hand-off.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_illegal;
        int          exp_latency;
    } vec_t;

    localparam int NUM_VECS = 20;
    localparam int MAX_WAIT = 64;

    logic clk;
    logic rst;
    int   vec_count;
    int   miscompares;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: bumps the vector count and reports a miscompare.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for out_valid, counting cycles since the accept edge.
    // Called at accept edge + 1 time unit.
    task automatic wait_result(output int lat, output logic [31:0] res,
                               output logic ill);
        lat = 1;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        ill = bus.illegal;
    endtask

    // Issues one request from IDLE, scrambles the inputs after acceptance,
    // waits for the result, then consumes it with a one-cycle out_ready.
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int lat,
                                  output logic [31:0] res, output logic ill);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_op   = op ^ 4'hF;
        bus.a        = ~a;
        bus.b        = ~b;
        wait_result(lat, res, ill);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs [NUM_VECS];
        int          lat;
        logic [31:0] res;
        logic        ill;
        logic        seen_valid;

        vec_count   = 0;
        miscompares = 0;

        // Hand-computed expected values.
        vecs[0]  = '{"addu_wrap", OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[1]  = '{"subu_neg",  OP_SUBU, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[2]  = '{"slt_neg",   OP_SLT,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[3]  = '{"sltu_neg",  OP_SLTU, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[4]  = '{"and",       OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[5]  = '{"or",        OP_OR,   32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0, 1};
        vecs[6]  = '{"xor",       OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1};
        vecs[7]  = '{"lui",       OP_LUI,  32'h5555_5555, 32'h1234_ABCD, 32'hABCD_0000, 1'b0, 1};
        vecs[8]  = '{"illegal15", 4'd15,   32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1};
        vecs[9]  = '{"nor_zero",  OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[10] = '{"illegal12", 4'd12,   32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{"sra_4",     OP_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 5};
        vecs[12] = '{"srl_4",     OP_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 5};
        vecs[13] = '{"sll_31",    OP_SLL,  32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 1'b0, 32};
        vecs[14] = '{"sll_0",     OP_SLL,  32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[15] = '{"sra_hi0",   OP_SRA,  32'hFFFF_FFE0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1};
        vecs[16] = '{"srl_1",     OP_SRL,  32'h0000_0001, 32'h8000_0001, 32'h4000_0000, 1'b0, 2};
        vecs[17] = '{"sra_8_pos", OP_SRA,  32'h0000_0008, 32'h7F00_FF00, 32'h007F_00FF, 1'b0, 9};
        vecs[18] = '{"sra_31",    OP_SRA,  32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[19] = '{"slt_pos",   OP_SLT,  32'h0000_0003, 32'h8000_0000, 32'h0000_0000, 1'b0, 1};

        // Reset state.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_output("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("reset_result",    bus.result,             32'd0);
        check_output("reset_illegal",   {31'd0, bus.illegal},   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table.
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, ill);
            check_output({vecs[i].name, "_result"},  res, vecs[i].exp_result);
            check_output({vecs[i].name, "_illegal"}, {31'd0, ill}, {31'd0, vecs[i].exp_illegal});
            check_output({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_latency));
            check_output({vecs[i].name, "_handoff"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        end

        // LUI result held for ten cycles of back-pressure while in_valid
        // pulses are presented and must be ignored.
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_LUI;
        bus.b        = 32'h1234_ABCD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_op   = OP_ADDU;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        for (int c = 0; c < 10; c++) begin
            check_output("lui_hold_result", bus.result, 32'hABCD_0000);
            check_output("lui_hold_flags",
                         {29'd0, bus.in_ready, bus.out_valid, bus.illegal}, 32'd2);
            bus.in_valid = c[0];
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_output("lui_release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        seen_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check_output("lui_no_queued_req", {31'd0, seen_valid}, 32'd0);

        // out_ready held high through the whole shift; it must not cut the
        // shift short, and the result is consumed on its first DONE cycle.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_op    = OP_SRL;
        bus.a         = 32'd3;
        bus.b         = 32'h0000_0080;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_result(lat, res, ill);
        check_output("srl_rdy_latency", 32'(lat), 32'd4);
        check_output("srl_rdy_result",  res, 32'h0000_0010);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_output("srl_rdy_handoff", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

        // Reset during the third SHIFT cycle of SLL by 20.
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_SLL;
        bus.a        = 32'd20;
        bus.b        = 32'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("rst_shift_state",
                     {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        check_output("rst_shift_result", bus.result, 32'd0);
        seen_valid = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check_output("rst_shift_no_valid", {31'd0, seen_valid}, 32'd0);
        apply_stimulus(OP_ADDU, 32'd2, 32'd3, lat, res, ill);
        check_output("post_rst_addu", res, 32'd5);
        check_output("post_rst_addu_latency", 32'(lat), 32'd1);

        // Reset in DONE colliding with out_ready: reset wins, result cleared.
        bus.in_valid = 1'b1;
        bus.alu_op   = OP_ADDU;
        bus.a        = 32'd7;
        bus.b        = 32'd8;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_output("done_before_rst", {31'd0, bus.out_valid}, 32'd1);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        check_output("rst_done_flags",
                     {29'd0, bus.in_ready, bus.out_valid, bus.illegal}, 32'd4);
        check_output("rst_done_result", bus.result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have one clock domain and a synchronous, active-high reset, with ports as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising clk edge.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 alu_op  input  4  operation code, ALUop.vh encoding: ADDU=0, SUBU=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, LUI=7, SLL=8, SRA=9, SRL=10, NOR=11, XXX=15.
REQ-007 a  input  32  operand A; A[4:0] is the shift amount for shifts.
REQ-008 b  input  32  operand B; the shifted value for shifts and the source for LUI.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  32  operation result.
REQ-012 illegal  output  1  result came from an undefined alu_op (12-15); valid only with out_valid.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready at a clk edge.
REQ-015 On acceptance, SHALL capture alu_op, a, and b into internal registers; inputs are don't-care afterwards.
REQ-016 Non-shift ops SHALL go IDLE->DONE, with out_valid asserted on the cycle after acceptance (latency 1).
REQ-017 ADDU/SUBU SHALL compute A+B / A-B modulo 2^32 with no overflow indication.
REQ-018 SLT SHALL return 1 if signed A<B, otherwise 0; SLTU SHALL do the same with unsigned compare; upper 31 bits SHALL be 0.
REQ-019 AND/OR/XOR/NOR SHALL be bitwise on A,B; LUI SHALL return {B[15:0],16'h0000}.
REQ-020 Undefined op (12-15) SHALL return result=0 with illegal=1 after latency 1; all defined ops SHALL set illegal=0.
REQ-021 SLL/SRL/SRA with A[4:0]=0 SHALL go IDLE->DONE with result=B (latency 1).
REQ-022 SLL/SRL/SRA with A[4:0]=n>0 SHALL go IDLE->SHIFT, shift the working register by exactly 1 bit per cycle for n cycles, then enter DONE; out_valid SHALL first assert n+1 cycles after acceptance.
REQ-023 SRA SHALL replicate the original B[31] into vacated bits; SLL/SRL SHALL fill vacated bits with 0.
REQ-024 Shift counter SHALL be 5 bits, load n, decrement per SHIFT cycle, and exit SHIFT when it reaches 0 (max 31 SHIFT cycles, no wrap).
REQ-025 In DONE, out_valid=1 and result/illegal SHALL hold stable until out_valid & out_ready.
REQ-026 On out_ready in DONE, SHALL return to IDLE next cycle; in_ready rises that cycle (one bubble; no same-cycle accept on hand-off).
REQ-027 out_ready outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored (no request is queued).
REQ-028 out_valid SHALL never be 1 in IDLE or SHIFT.

Reset
REQ-029 rst SHALL force, on the next clk edge: state=IDLE, out_valid=0, result=0, illegal=0, shift counter=0, in_ready=1 from the following cycle.
REQ-030 rst asserted in SHIFT or DONE SHALL abandon the operation, produce no out_valid, and take precedence over any handshake in the same cycle.

Verification
REQ-031 ADDU a=32'hFFFF_FFFF, b=1 -> out_valid one cycle after accept, result=0, illegal=0.
REQ-032 SLT a=32'hFFFF_FFFE (-2), b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-033 SRA a=4, b=32'h8000_0000 -> out_valid exactly 5 cycles after accept, result=32'hF800_0000; SRL with the same operands -> 32'h0800_0000; SLL a=31, b=1 -> 32'h8000_0000 after 32 cycles.
REQ-034 LUI b=32'h1234_ABCD, out_ready held 0 for 10 cycles -> result=32'hABCD_0000 stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 alu_op=15 -> result=0, illegal=1 after 1 cycle; a following NOR a=0, b=0 -> result=32'hFFFF_FFFF, illegal=0.
REQ-036 rst during the 3rd SHIFT cycle of SLL a=20 -> no out_valid, in_ready=1 the cycle after reset deasserts, next ADDU 2+3 -> 5.
